digi_ota_sd_driver: RTL and testbench



---
 rtl/digi_ota_pkg.sv | 16 +
 rtl/digi_ota_sync_edge.sv | 22 ++
 rtl/digi_ota_sd_driver.sv | 149 ++++++++++++++
 tb/tb_digi_ota_sd_driver.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/digi_ota_pkg.sv
// Shared encodings for the OTA sigma-delta stimulus driver.
// Latency: none (types and constants only).
// Backpressure: none.
package digi_ota_pkg;
    localparam int CODE_W = 8;

    localparam logic [1:0] MODE_STATIC = 2'd0;
    localparam logic [1:0] MODE_RAMP   = 2'd1;
    localparam logic [1:0] MODE_TRI    = 2'd2;

    typedef enum logic { DIR_UP = 1'b0, DIR_DOWN = 1'b1 } dir_t;

    function automatic logic is_sweep(input logic [1:0] mode);
        return (mode == MODE_RAMP) || (mode == MODE_TRI);
    endfunction
endpackage

// File: rtl/digi_ota_sync_edge.sv
// Two-flop synchronizer plus rising-edge detect for an asynchronous pad strobe.
// Latency: rise is high two clk edges after din goes high, for one cycle.
// Backpressure: none; ena low freezes the pipeline.
module digi_ota_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic ena,
    input  logic din,
    output logic rise
);
    logic [2:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else if (ena) begin
            sync_q <= {sync_q[1:0], din};
        end
    end

    assign rise = sync_q[1] & ~sync_q[2];
endmodule

// File: rtl/digi_ota_sd_driver.sv
// First-order sigma-delta stimulus for the OTA input pair, with static/ramp/triangle code sources.
// Latency: outputs follow the modulator tick by one clk; load reaches code_now three clks after it rises.
// Backpressure: none; ena low freezes all state and forces both outputs low.
module digi_ota_sd_driver
    import digi_ota_pkg::*;
#(
    parameter int DIV  = 4,
    parameter int DEAD = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic [CODE_W-1:0] code_in,
    input  logic              load,
    input  logic [1:0]        mode,
    output logic              vp_out,
    output logic              vn_out,
    output logic [CODE_W-1:0] code_now,
    output logic              sweep_done
);
    localparam int TW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int DW = $clog2(DEAD + 2);
    localparam logic [TW-1:0] TICK_LAST = TW'(DIV - 1);
    localparam logic [DW-1:0] DEAD_LEN  = DW'(DEAD);

    logic [TW-1:0]     tick_cnt;
    logic [CODE_W-1:0] acc;
    logic [7:0]        period_cnt;
    logic [DW-1:0]     dead_cnt;
    logic [DW-1:0]     dead_nxt;
    logic              mod_bit;
    logic              bit_nxt;
    dir_t              dir;
    dir_t              dir_nxt;
    logic [1:0]        mode_q;
    logic [CODE_W-1:0] code_nxt;
    logic              done_nxt;
    logic              tick;
    logic              wrap;
    logic              load_rise;
    logic              enter_sweep;
    logic              swap_sweep;
    logic [CODE_W:0]   sum;

    digi_ota_sync_edge u_load_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .ena  (ena),
        .din  (load),
        .rise (load_rise)
    );

    // Modulator and non-overlap timing
    always_comb begin
        tick        = (tick_cnt == TICK_LAST);
        wrap        = tick && (period_cnt == '1);
        sum         = {1'b0, acc} + {1'b0, code_now};
        bit_nxt     = tick ? sum[CODE_W] : mod_bit;
        enter_sweep = is_sweep(mode) && !is_sweep(mode_q);
        swap_sweep  = is_sweep(mode) && is_sweep(mode_q) && (mode != mode_q);
        // A bit change during dead time restarts the gap so the pair never overlaps.
        if (tick && (sum[CODE_W] != mod_bit)) begin
            dead_nxt = DEAD_LEN;
        end else if (dead_cnt != '0) begin
            dead_nxt = dead_cnt - DW'(1);
        end else begin
            dead_nxt = '0;
        end
    end

    // Code source: mode-entry clear beats load, which beats the sweep step
    always_comb begin
        code_nxt = code_now;
        dir_nxt  = dir;
        done_nxt = 1'b0;
        if (enter_sweep) begin
            code_nxt = '0;
            dir_nxt  = DIR_UP;
        end else if (!is_sweep(mode)) begin
            if (load_rise) begin
                code_nxt = code_in;
            end
        end else begin
            if (swap_sweep) begin
                dir_nxt = DIR_UP;
            end
            if (wrap) begin
                if (mode == MODE_RAMP) begin
                    code_nxt = code_now + CODE_W'(1);
                    done_nxt = (code_now == '1);
                end else if (dir_nxt == DIR_UP) begin
                    // Arriving at the top from ramp mode turns straight around.
                    if (code_now == '1) begin
                        code_nxt = code_now - CODE_W'(1);
                        dir_nxt  = DIR_DOWN;
                    end else begin
                        code_nxt = code_now + CODE_W'(1);
                        if (code_now == CODE_W'(254)) begin
                            dir_nxt = DIR_DOWN;
                        end
                    end
                end else begin
                    code_nxt = code_now - CODE_W'(1);
                    if (code_now == CODE_W'(1)) begin
                        dir_nxt  = DIR_UP;
                        done_nxt = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt   <= '0;
            acc        <= '0;
            period_cnt <= '0;
            dead_cnt   <= '0;
            mod_bit    <= 1'b0;
            dir        <= DIR_UP;
            mode_q     <= MODE_STATIC;
            code_now   <= '0;
            sweep_done <= 1'b0;
            vp_out     <= 1'b0;
            vn_out     <= 1'b0;
        end else if (!ena) begin
            vp_out     <= 1'b0;
            vn_out     <= 1'b0;
            sweep_done <= 1'b0;
        end else begin
            tick_cnt   <= tick ? '0 : tick_cnt + TW'(1);
            mod_bit    <= bit_nxt;
            dead_cnt   <= dead_nxt;
            vp_out     <= (dead_nxt == '0) && bit_nxt;
            vn_out     <= (dead_nxt == '0) && !bit_nxt;
            mode_q     <= mode;
            code_now   <= code_nxt;
            dir        <= dir_nxt;
            sweep_done <= done_nxt;
            if (enter_sweep) begin
                acc        <= '0;
                period_cnt <= '0;
            end else if (tick) begin
                acc        <= sum[CODE_W-1:0];
                period_cnt <= period_cnt + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_digi_ota_sd_driver.sv
// Directed/randomized bench for digi_ota_sd_driver: three instances (DIV/DEAD = 1/0, 4/0, 4/2)
// share stimulus; each has its own reset so one can be reset mid-sweep.
module tb_digi_ota_sd_driver;
    logic       clk = 1'b0;
    logic       rst_a, rst_b, rst_c;
    logic       ena, load;
    logic [7:0] code_in;
    logic [1:0] mode;
    logic       a_vp, a_vn, a_done, b_vp, b_vn, b_done, c_vp, c_vn, c_done;
    logic [7:0] a_code, b_code, c_code;
    int         vectors = 0;
    int         fails   = 0;

    always #5 clk = ~clk;

    digi_ota_sd_driver #(.DIV(1), .DEAD(0)) u_a (
        .clk(clk), .rst_n(rst_a), .ena(ena), .code_in(code_in), .load(load), .mode(mode),
        .vp_out(a_vp), .vn_out(a_vn), .code_now(a_code), .sweep_done(a_done));
    digi_ota_sd_driver #(.DIV(4), .DEAD(0)) u_b (
        .clk(clk), .rst_n(rst_b), .ena(ena), .code_in(code_in), .load(load), .mode(mode),
        .vp_out(b_vp), .vn_out(b_vn), .code_now(b_code), .sweep_done(b_done));
    digi_ota_sd_driver #(.DIV(4), .DEAD(2)) u_c (
        .clk(clk), .rst_n(rst_c), .ena(ena), .code_in(code_in), .load(load), .mode(mode),
        .vp_out(c_vp), .vn_out(c_vn), .code_now(c_code), .sweep_done(c_done));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [7:0] c);
        code_in = c;
        load    = 1'b1;
        repeat (3) step();
        load    = 1'b0;
    endtask

    // Carry out of tick k when a zeroed accumulator integrates code c.
    function automatic logic sd_bit(input int k, input int c);
        return (((k * c) >> 8) - (((k - 1) * c) >> 8)) != 0;
    endfunction

    // Triangle code after p periods starting from 0 going up.
    function automatic int tri_val(input int p);
        int q;
        q = p % 510;
        return (q <= 255) ? q : 510 - q;
    endfunction

    always @(negedge clk) begin
        check("a_overlap", 32'(a_vp & a_vn), 32'd0);
        check("b_overlap", 32'(b_vp & b_vn), 32'd0);
        check("c_overlap", 32'(c_vp & c_vn), 32'd0);
    end

    initial begin
        int   r, k, ca, cb, run, nruns, p, exp_code, exp_done;
        int   codes[3];
        logic eb;

        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        ena = 1'b0; load = 1'b0; mode = 2'd0; code_in = 8'd0;
        #12;
        check("rst_a_vp", 32'(a_vp), 32'd0);     check("rst_a_vn", 32'(a_vn), 32'd0);
        check("rst_a_code", 32'(a_code), 32'd0); check("rst_a_done", 32'(a_done), 32'd0);
        check("rst_b_vp", 32'(b_vp), 32'd0);     check("rst_b_vn", 32'(b_vn), 32'd0);
        check("rst_b_code", 32'(b_code), 32'd0); check("rst_b_done", 32'(b_done), 32'd0);
        check("rst_c_vp", 32'(c_vp), 32'd0);     check("rst_c_vn", 32'(c_vn), 32'd0);
        check("rst_c_code", 32'(c_code), 32'd0); check("rst_c_done", 32'(c_done), 32'd0);
        step();
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1; ena = 1'b1;

        // Code 0: constant low on vp, high on vn
        do_load(8'd0);
        repeat (8) step();
        for (int i = 0; i < 512; i++) begin
            step();
            check("zero_a_vp", 32'(a_vp), 32'd0); check("zero_a_vn", 32'(a_vn), 32'd1);
            check("zero_b_vp", 32'(b_vp), 32'd0); check("zero_b_vn", 32'(b_vn), 32'd1);
        end

        // Load latency and the code-128 pattern; instance C shows the dead gaps
        code_in = 8'd128;
        load    = 1'b1;
        step(); check("lat1", 32'(a_code), 32'd0);
        step(); check("lat2", 32'(a_code), 32'd0);
        step(); check("lat3", 32'(a_code), 32'd128);
        load  = 1'b0;
        run   = -1;
        nruns = 0;
        for (int kk = 1; kk <= 128; kk++) begin
            step();
            eb = sd_bit(kk, 128);
            check("seq128_vp", 32'(a_vp), 32'(eb));
            check("seq128_vn", 32'(a_vn), 32'(!eb));
            if (!c_vp && !c_vn) begin
                if (run >= 0) run++;
            end else begin
                if (run > 0) begin
                    check("dead_len", run, 32'd2);
                    nruns++;
                end
                run = 0;
            end
        end
        check("dead_runs", 32'(nruns >= 20), 32'd1);

        // Random code from a fresh accumulator, with a 100-cycle ena-low gap
        rst_a = 1'b0;
        step();
        rst_a = 1'b1;
        r = $urandom_range(1, 254);
        do_load(8'(r));
        k = 0;
        for (int i = 1; i <= 400; i++) begin
            if (i == 151) ena = 1'b0;
            if (i == 251) ena = 1'b1;
            step();
            if (i >= 151 && i <= 250) begin
                check("frz_vp", 32'(a_vp), 32'd0);
                check("frz_vn", 32'(a_vn), 32'd0);
                check("frz_code", 32'(a_code), 32'(r));
            end else begin
                k++;
                eb = sd_bit(k, r);
                check("rnd_vp", 32'(a_vp), 32'(eb));
                check("rnd_vn", 32'(a_vn), 32'(!eb));
            end
        end

        // Pulse density over one full accumulator cycle
        codes[0] = 64;
        codes[1] = 255;
        codes[2] = $urandom_range(1, 254);
        for (int j = 0; j < 3; j++) begin
            do_load(8'(codes[j]));
            repeat (8) step();
            ca = 0;
            cb = 0;
            for (int i = 0; i < 1024; i++) begin
                step();
                if (i < 256) ca += int'(a_vp);
                cb += int'(b_vp);
            end
            check("density_a", ca, codes[j]);
            check("density_b", cb, 4 * codes[j]);
        end

        // Triangle from 0 through the top, then ramp through the 255->0 wrap.
        // Instance B (period 1024 clks) is reset asynchronously at code 37.
        mode = 2'd2;
        step();
        check("enter_clear", 32'(a_code), 32'd0);
        for (int n = 1; n <= 66112; n++) begin
            if (n == 65665) mode = 2'd1;
            step();
            p = n / 256;
            exp_code = (n < 65665) ? tri_val(p) : (254 + p - 256) % 256;
            exp_done = ((n % 256) == 0 && p > 0 && exp_code == 0) ? 1 : 0;
            check("sweep_code", 32'(a_code), exp_code);
            check("sweep_done", 32'(a_done), exp_done);
            if (n == 37 * 1024 + 500) begin
                check("b_code37", 32'(b_code), 32'd37);
                rst_b = 1'b0;
                #1;
                check("arst_vp", 32'(b_vp), 32'd0);
                check("arst_vn", 32'(b_vn), 32'd0);
                check("arst_code", 32'(b_code), 32'd0);
                check("arst_done", 32'(b_done), 32'd0);
            end
        end
        rst_b = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end
endmodule
